ysyx_22040759_lsu_ctrl: RTL and testbench
=========================================

// Module: ysyx_22040759_lsu_ctrl
// PURPOSE
//  Multi-cycle load/store sequencer between the decode/control stage and the data-memory bus.
//  Takes mem_ren/mem_wen/func3 from decode and the ALU address, runs one valid/ready request
//  plus response transaction per access, and holds the PC via stall until the access completes.
//  Produces byte masks and shifted write data; extracts and sign/zero-extends load data for writeback.
// PARAMETERS
//  TIMEOUT  255  max cycles spent in REQ+WAIT before aborting with err (>=1)
// PORTS
//  clk          in   1   core clock
//  rst_n        in   1   asynchronous active-low reset
//  mem_ren      in   1   decoded load (ld/lw/...)
//  mem_wen      in   1   decoded store
//  func3        in   3   access size/sign (inst[14:12])
//  addr         in   64  effective address from ALU
//  wdata        in   64  store data (rs2), LSB-aligned
//  stall        out  1   hold PC/regfile write this cycle
//  done         out  1   1-cycle pulse: access finished (ld_data valid when load)
//  err          out  1   with done: misaligned / illegal func3 / ren&wen / timeout
//  ld_data      out  64  extended load result, held until next access starts
//  req_valid    out  1   bus request valid
//  req_ready    in   1   bus accepts request
//  req_wen      out  1   1=write, 0=read
//  req_addr     out  64  addr with [2:0] cleared (doubleword aligned)
//  req_wdata    out  64  wdata shifted left by addr[2:0]*8
//  req_wmask    out  8   byte lane enables (0 for reads)
//  resp_valid   in   1   bus response valid (read data or write ack)
//  resp_ready   out  1   high only in WAIT
//  resp_rdata   in   64  raw doubleword read data
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, stall=0, done=0, err=0, req_valid=0, resp_ready=0,
//   ld_data=0, timeout counter=0; an in-flight request is dropped immediately.
//  States: IDLE, REQ, WAIT, DONE (encodings from shared define file).
//  IDLE: if mem_ren|mem_wen: stall=1 combinationally; latch addr/wdata/func3/dir.
//   Legal -> REQ. Illegal (misaligned, ren&wen both 1, load func3=111, store func3[2]=1) -> DONE, err=1, no bus traffic.
//  Alignment: size by func3[1:0] (00 B,01 H,10 W,11 D); misaligned if addr[size-1:0]!=0.
//  REQ: req_valid=1, req_* driven from latched regs, stable until req_valid&req_ready -> WAIT.
//  WAIT: resp_ready=1; resp_valid -> DONE; loads capture extended data into ld_data that edge.
//  Timeout: counter clears on IDLE exit, increments each REQ/WAIT cycle; on reaching TIMEOUT
//   -> DONE with err=1, req_valid dropped; late response ignored (resp_ready=0 outside WAIT).
//  DONE: done=1, stall=0 for exactly one cycle -> IDLE. Inputs in DONE are ignored (still
//   old instruction); a new access can start no earlier than the following IDLE cycle.
//  stall = (IDLE & (mem_ren|mem_wen)) | REQ | WAIT. Min latency legal access: 4 cycles
//   (IDLE,REQ w/ ready,WAIT w/ resp,DONE); ld_data valid from DONE cycle.
//  Load extract: rdata>>(addr[2:0]*8), then lb/lh/lw sign-extend, lbu/lhu/lwu zero-extend, ld raw.
//  Store mask: B 8'b1<<a, H 8'b11<<a, W 8'h0F<<a, D 8'hFF (a=addr[2:0]).
//  err only meaningful when done=1; err=0 otherwise.
// STRUCTURE
//  State encodings, size codes and func3 load/store values as `defines in ysyx_22040759_define.v.
//  Sub-module ysyx_22040759_lsu_align: combinational mask/wdata shift, rdata extract+extend,
//  misalign/illegal detect; lsu_ctrl keeps FSM, latches and timeout counter.
// TESTING
//  ld addr=0x80000008, req_ready=1, resp 1 cycle later rdata=0x1122334455667788 -> done at cycle 4, ld_data=0x1122334455667788, err=0.
//  lb addr=0x80000003, rdata=0x00000000_80FF0000 byte3=0x80 -> ld_data=0xFFFFFFFFFFFFFF80; lbu -> 0x80.
//  sh addr=0x80000006 wdata=0xABCD -> req_wmask=8'hC0, req_wdata=0xABCD000000000000, req_addr=0x80000000.
//  lw addr=0x80000002 -> no req_valid ever, done=1 err=1 in 2nd cycle; sd ren&wen=1 -> same.
//  req_ready held 0 for 300 cycles, TIMEOUT=255 -> done&err after 255 REQ cycles, req_valid low next cycle.
//  rst_n=0 while in WAIT -> req_valid/resp_ready/stall 0 immediately; after release, new ld completes normally.

Source files
------------

// File: rtl/ysyx_22040759_lsu_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer.
//   lsu_state_e : sequencer states (IDLE, REQ, WAIT, DONE)
//   SZ_*        : access size codes carried in func3[1:0]
//   F3_*        : load/store func3 encodings
//   lsu_acc_t   : access latched when leaving IDLE
package ysyx_22040759_lsu_ctrl_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned MASK_W = XLEN / 8;
  localparam int unsigned OFF_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic            wen;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_acc_t;

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Combinational data-path helper for the load/store sequencer.
//   func3_i/off_i : access size/sign and byte offset within the doubleword
//   ren_i/wen_i   : decoded direction, used only for legality
//   wdata_i       : LSB-aligned store data -> wdata_o shifted into its lanes
//   wmask_o       : byte lane enables for the access size
//   rdata_i       : raw doubleword read data -> rdata_o extracted and extended
//   illegal_o     : misaligned, both directions, or unsupported func3
module ysyx_22040759_lsu_align
  import ysyx_22040759_lsu_ctrl_pkg::*;
(
  input  logic [2:0]        func3_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic              ren_i,
  input  logic              wen_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [MASK_W-1:0] wmask_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              illegal_o
);

  logic            misaligned;
  logic            bad_func3;
  logic [XLEN-1:0] rshift;

  // Size decode: misalignment and byte lanes
  always_comb begin
    misaligned = 1'b0;
    wmask_o    = '0;
    case (func3_i[1:0])
      SZ_B: begin
        misaligned = 1'b0;
        wmask_o    = 8'h01 << off_i;
      end
      SZ_H: begin
        misaligned = off_i[0];
        wmask_o    = 8'h03 << off_i;
      end
      SZ_W: begin
        misaligned = |off_i[1:0];
        wmask_o    = 8'h0F << off_i;
      end
      default: begin
        misaligned = |off_i;
        wmask_o    = 8'hFF;
      end
    endcase
  end

  // Loads have no func3=111; stores only use the unsigned-free codes 000..011
  assign bad_func3 = (ren_i && (func3_i == 3'b111)) || (wen_i && func3_i[2]);
  assign illegal_o = misaligned || (ren_i && wen_i) || bad_func3;

  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign rshift  = rdata_i >> {off_i, 3'b000};

  // Load extract and extend
  always_comb begin
    rdata_o = '0;
    case (func3_i)
      F3_LB:   rdata_o = {{56{rshift[7]}},  rshift[7:0]};
      F3_LH:   rdata_o = {{48{rshift[15]}}, rshift[15:0]};
      F3_LW:   rdata_o = {{32{rshift[31]}}, rshift[31:0]};
      F3_LD:   rdata_o = rshift;
      F3_LBU:  rdata_o = {56'd0, rshift[7:0]};
      F3_LHU:  rdata_o = {48'd0, rshift[15:0]};
      F3_LWU:  rdata_o = {32'd0, rshift[31:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_lsu_ctrl.sv
// Multi-cycle load/store sequencer between decode and the data-memory bus.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   mem_ren/mem_wen/func3/addr/wdata: access request from decode/ALU
//   stall                          : hold PC/regfile while an access is in flight
//   done/err/ld_data               : completion pulse, error flag, extended load data
//   req_*                          : valid/ready bus request (aligned addr, lanes, mask)
//   resp_*                         : valid/ready bus response (read data or write ack)
module ysyx_22040759_lsu_ctrl
  import ysyx_22040759_lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   ld_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wen,
  output logic [XLEN-1:0]   req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [MASK_W-1:0] req_wmask,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [XLEN-1:0]   resp_rdata
);

  localparam int unsigned     CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_acc_t          acc_q, acc_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;

  logic              in_idle;
  logic              access;
  logic [2:0]        al_func3;
  logic [OFF_W-1:0]  al_off;
  logic              al_illegal;
  logic [MASK_W-1:0] al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic              expired;

  assign in_idle = (state_q == ST_IDLE);
  assign access  = mem_ren || mem_wen;

  // Legality is judged on live inputs in IDLE; afterwards the latched access drives the lanes
  assign al_func3 = in_idle ? func3      : acc_q.func3;
  assign al_off   = in_idle ? addr[2:0]  : acc_q.addr[2:0];

  ysyx_22040759_lsu_align u_align (
    .func3_i   (al_func3),
    .off_i     (al_off),
    .ren_i     (mem_ren),
    .wen_i     (mem_wen),
    .wdata_i   (acc_q.wdata),
    .rdata_i   (resp_rdata),
    .wmask_o   (al_wmask),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .illegal_o (al_illegal)
  );

  // Counter holds the number of REQ/WAIT cycles already spent
  assign expired = (cnt_q >= CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    err_d     = 1'b0;
    ld_data_d = ld_data_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          acc_d = '{wen: mem_wen, func3: func3, addr: addr, wdata: wdata};
          cnt_d = '0;
          if (al_illegal) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (req_ready) begin
          state_d = ST_WAIT;
        end else if (expired) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (resp_valid) begin
          state_d = ST_DONE;
          if (!acc_q.wen) begin
            ld_data_d = al_rdata;
          end
        end else if (expired) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset also masks the combinational IDLE stall so the PC is free during reset
  assign stall      = rst_n && ((in_idle && access) || (state_q == ST_REQ) || (state_q == ST_WAIT));
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign ld_data    = ld_data_q;
  assign req_valid  = (state_q == ST_REQ);
  assign resp_ready = (state_q == ST_WAIT);
  assign req_wen    = acc_q.wen;
  assign req_addr   = {acc_q.addr[XLEN-1:3], 3'b000};
  assign req_wdata  = al_wdata;
  assign req_wmask  = acc_q.wen ? al_wmask : '0;

endmodule

// File: tb/tb_ysyx_22040759_lsu_ctrl.sv
module tb_ysyx_22040759_lsu_ctrl;

  localparam int unsigned TO   = 255;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_ren, mem_wen;
  logic [2:0]  func3;
  logic [63:0] addr, wdata;
  logic        stall, done, err;
  logic [63:0] ld_data;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;

  ysyx_22040759_lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .func3      (func3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .ld_data    (ld_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic        err;
    logic [63:0] ld;
    int          lat;
    int          issue;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  exp_t        sb[$];
  req_t        rq[$];
  bit          busy = 1'b0;
  int          mode = 4;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] last_ld = '0;

  // Responder sampling (taken at negedge, consumed at next posedge)
  logic        s_hs = 1'b0, s_rs = 1'b0;
  logic [63:0] s_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  // Reference load: gather size bytes from offset, then extend
  function automatic logic [63:0] ref_load(input logic [63:0] dw, input int off, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", 64'(stall), 64'(busy && !done));
      if (!done) chk("err_without_done", 64'(err), 64'd0);
      if (req_valid && req_ready) begin
        if (rq.size() == 0) flag("unexpected_request");
        else begin
          req_t r;
          r = rq.pop_front();
          chk("req_addr", req_addr, r.addr);
          chk("req_wen", 64'(req_wen), 64'(r.wen));
          chk("req_wdata", req_wdata, r.wdata);
          chk("req_wmask", 64'(req_wmask), 64'(r.wmask));
        end
      end else if (req_valid && rq.size() == 0) begin
        flag("req_valid_without_access");
      end
      if (done) begin
        if (sb.size() == 0) flag("unexpected_done");
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("err", 64'(err), 64'(e.err));
          chk("ld_data", ld_data, e.ld);
          if (e.lat != 0) chk("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
        end
        busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    s_hs   = rst_n && req_valid && req_ready;
    s_rs   = rst_n && resp_valid && resp_ready;
    s_addr = req_addr;
  end

  // Bus responder: mode 0 random, 1 never ready, 2 never respond, 3 late respond, 4 fast
  initial begin
    bit          pend;
    int          dly;
    logic [63:0] pend_addr;
    pend = 1'b0; dly = 0; pend_addr = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        pend       = 1'b0;
      end else begin
        if (resp_valid && (s_rs || mode == 3)) resp_valid = 1'b0;
        if (s_hs && mode != 2) begin
          pend      = 1'b1;
          pend_addr = s_addr;
          dly       = (mode == 0) ? int'($urandom_range(0, 3)) : (mode == 3) ? int'(TO) + 5 : 0;
        end
        if (pend) begin
          if (dly == 0) begin
            resp_valid = 1'b1;
            resp_rdata = mem_rd(pend_addr);
            pend       = 1'b0;
          end else dly--;
        end
        case (mode)
          0:       req_ready = ($urandom_range(0, 3) != 0);
          1:       req_ready = 1'b0;
          default: req_ready = 1'b1;
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one access at posedge+#1 in IDLE; returns at posedge+#1 of the IDLE after DONE
  task automatic access(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input int md, input int lat);
    int          n, off;
    logic [63:0] al, dw;
    logic [7:0]  m;
    bit          illegal, got;
    exp_t        e;
    req_t        r;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    al  = {a[63:3], 3'b000};
    illegal = (off % n != 0) || (ren && wen) || (ren && f3 == 3'b111) || (wen && f3[2]);
    mode    = md;
    e.issue = cyc;
    e.lat   = lat;
    if (illegal) begin
      e.err = 1'b1;
    end else begin
      m = '0;
      for (int i = 0; i < n; i++) m[off+i] = wen;
      r.addr = al; r.wen = wen; r.wdata = wd << (8*off); r.wmask = m;
      rq.push_back(r);
      if (md == 1 || md == 2 || md == 3) begin
        e.err = 1'b1;
      end else begin
        e.err = 1'b0;
        dw = mem_rd(al);
        if (ren) last_ld = ref_load(dw, off, f3);
        else begin
          for (int i = 0; i < n; i++) dw[8*(off+i) +: 8] = wd[8*i +: 8];
          mem[al] = dw;
        end
      end
    end
    e.ld = last_ld;
    sb.push_back(e);
    mem_ren = ren; mem_wen = wen; func3 = f3; addr = a; wdata = wd;
    busy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < int'(TO) + 50; i++) begin
      @(posedge clk);
      if (!busy) begin got = 1'b1; break; end
    end
    if (!got) begin
      flag("done_never_seen");
      busy = 1'b0;
      sb.delete();
    end
    #1;
    mem_ren = 1'b0; mem_wen = 1'b0;
    rq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sel, sz, off;
    logic [2:0]  f3;
    logic [63:0] a;
    rst_n = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; func3 = '0; addr = '0; wdata = '0;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_resp_ready", 64'(resp_ready), 64'd0);
    chk("rst_ld_data", ld_data, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Doubleword load, fastest bus
    mem[BASE + 64'h8] = 64'h1122_3344_5566_7788;
    access(1'b1, 1'b0, 3'b011, BASE + 64'h8, '0, 4, 4);
    chk("ld_value", ld_data, 64'h1122_3344_5566_7788);

    // Signed and unsigned byte loads
    mem[BASE] = 64'h0000_0000_80FF_0000;
    access(1'b1, 1'b0, 3'b000, BASE + 64'h3, '0, 4, 4);
    chk("lb_value", ld_data, 64'hFFFF_FFFF_FFFF_FF80);
    access(1'b1, 1'b0, 3'b100, BASE + 64'h3, '0, 4, 4);
    chk("lbu_value", ld_data, 64'h0000_0000_0000_0080);

    // Halfword store into top lanes
    access(1'b0, 1'b1, 3'b001, BASE + 64'h6, 64'hABCD, 4, 4);

    // Illegal: misaligned lw and ren&wen sd
    access(1'b1, 1'b0, 3'b010, BASE + 64'h2, '0, 4, 2);
    access(1'b1, 1'b1, 3'b011, BASE + 64'h10, 64'h55, 4, 2);

    // Request never accepted, then response that never arrives (late one ignored)
    access(1'b1, 1'b0, 3'b011, BASE + 64'h18, '0, 1, int'(TO) + 2);
    chk("req_valid_after_timeout", 64'(req_valid), 64'd0);
    access(1'b1, 1'b0, 3'b011, BASE + 64'h20, '0, 3, int'(TO) + 2);
    idle(20);

    // Reset while waiting for a response
    mode = 2;
    begin
      req_t r;
      bit   seen;
      r.addr = BASE + 64'h28; r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
      rq.push_back(r);
      mem_ren = 1'b1; mem_wen = 1'b0; func3 = 3'b011; addr = BASE + 64'h28; wdata = '0;
      busy = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (resp_ready) begin seen = 1'b1; break; end
      end
      chk("reached_wait", 64'(seen), 64'd1);
      #2;
      rst_n = 1'b0; mem_ren = 1'b0; busy = 1'b0;
      sb.delete(); rq.delete();
      #1;
      chk("wait_rst_req_valid", 64'(req_valid), 64'd0);
      chk("wait_rst_resp_ready", 64'(resp_ready), 64'd0);
      chk("wait_rst_stall", 64'(stall), 64'd0);
      chk("wait_rst_done", 64'(done), 64'd0);
      chk("wait_rst_ld_data", ld_data, 64'd0);
      last_ld = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
    end
    access(1'b1, 1'b0, 3'b011, BASE + 64'h8, '0, 4, 4);
    chk("ld_after_reset", ld_data, 64'h1122_3344_5566_7788);

    // Randomized traffic against the reference model
    for (int k = 0; k < 80; k++) begin
      f3  = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 9));
      sz  = 1 << f3[1:0];
      off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                        : (int'($urandom_range(0, 7)) / sz) * sz;
      a   = BASE + 64'({$urandom_range(0, 7), 3'b000}) + 64'(off);
      access(sel < 5 || sel == 9, sel >= 5, f3, a, {$urandom, $urandom}, 0, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
